sdram_ctrl_fsm: RTL and testbench

SDRAM_CTRL_FSM -- requirements
Module: sdram_ctrl_fsm

---
 rtl/sdram_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_sdram_ctrl_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ctrl_fsm.sv
// SDRAM control-state sequencer: power-up init chain, then a work FSM arbitrating refresh/write/read.
// Optional macro SDRAM_SIM_FAST_INIT_EN shortens the power-up NOP wait to 16 cycles for simulation.
module sdram_ctrl_fsm #(
    parameter int T_PWRUP = 10000,
    parameter int T_REFI  = 780,
    parameter int T_TRP   = 1,
    parameter int T_TRF   = 4,
    parameter int T_TMRD  = 2,
    parameter int T_TRCD  = 1,
    parameter int T_CL    = 2,
    parameter int T_BL    = 8,
    parameter int T_TDAL  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic       rd_req,
    output logic [4:0] init_state,
    output logic [3:0] work_state,
    output logic       wr_ack,
    output logic       rd_ack,
    output logic       wr_data_en,
    output logic       rd_data_en,
    output logic       sdram_busy
);

`ifdef SDRAM_SIM_FAST_INIT_EN
    localparam int NOP_WAIT = 16;
`else
    localparam int NOP_WAIT = T_PWRUP;
`endif
    localparam int CNT_W = ($clog2(NOP_WAIT + 1) > 14) ? $clog2(NOP_WAIT + 1) : 14;
    localparam int REF_W = $clog2(T_REFI + 1);

    typedef enum logic [4:0] {
        I_NOP  = 5'd0,  I_PRE  = 5'd1,  I_TRP  = 5'd2,
        I_AR1  = 5'd3,  I_TRF1 = 5'd4,  I_AR2  = 5'd5,  I_TRF2 = 5'd6,
        I_AR3  = 5'd7,  I_TRF3 = 5'd8,  I_AR4  = 5'd9,  I_TRF4 = 5'd10,
        I_AR5  = 5'd11, I_TRF5 = 5'd12, I_AR6  = 5'd13, I_TRF6 = 5'd14,
        I_AR7  = 5'd15, I_TRF7 = 5'd16, I_AR8  = 5'd17, I_TRF8 = 5'd18,
        I_MRS  = 5'd19, I_TMRD = 5'd20, I_DONE = 5'd21
    } init_state_e;

    typedef enum logic [3:0] {
        W_IDLE  = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3,
        W_CL    = 4'd4, W_RD     = 4'd5, W_WRITE = 4'd6, W_WD  = 4'd7,
        W_TDAL  = 4'd8, W_AR     = 4'd9, W_TRFC = 4'd10
    } work_state_e;

    init_state_e      init_q, init_d;
    work_state_e      work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_pend_q, ref_pend_d;
    logic             is_wr_q, is_wr_d;
    int               cur_dur;
    logic             wait_done;
    logic             ref_wrap;

    // Dwell time of the current state; the shared counter is compared against it.
    always_comb begin
        cur_dur = 1;
        if (init_q != I_DONE) begin
            case (init_q)
                I_NOP:   cur_dur = NOP_WAIT;
                I_TRP:   cur_dur = T_TRP;
                I_TMRD:  cur_dur = T_TMRD;
                default: cur_dur = (!init_q[0] && init_q >= I_TRF1 && init_q <= I_TRF8) ? T_TRF : 1;
            endcase
        end else begin
            case (work_q)
                W_TRCD:  cur_dur = T_TRCD;
                W_CL:    cur_dur = T_CL;
                W_RD:    cur_dur = T_BL;
                W_WD:    cur_dur = T_BL - 1;
                W_TDAL:  cur_dur = T_TDAL;
                W_TRFC:  cur_dur = T_TRF;
                default: cur_dur = 1;
            endcase
        end
    end

    assign wait_done = (cnt_q == CNT_W'(cur_dur - 1));
    assign ref_wrap  = (init_q == I_DONE) && (ref_cnt_q == REF_W'(T_REFI - 1));

    // Requests are levels held by the user until the matching one-cycle ack; they are
    // sampled only in W_IDLE, and the chosen path is latched in is_wr_q at that point.
    always_comb begin
        init_d  = init_q;
        work_d  = work_q;
        is_wr_d = is_wr_q;
        if (init_q != I_DONE) begin
            work_d = W_IDLE;
            if (wait_done) init_d = init_state_e'(init_q + 5'd1);
        end else begin
            case (work_q)
                W_IDLE: begin
                    if (ref_pend_q) begin
                        work_d = W_AR;
                    end else if (wr_req) begin
                        work_d  = W_ACTIVE;
                        is_wr_d = 1'b1;
                    end else if (rd_req) begin
                        work_d  = W_ACTIVE;
                        is_wr_d = 1'b0;
                    end
                end
                W_ACTIVE: work_d = W_TRCD;
                W_TRCD:   if (wait_done) work_d = is_wr_q ? W_WRITE : W_READ;
                W_READ:   work_d = W_CL;
                W_CL:     if (wait_done) work_d = W_RD;
                W_RD:     if (wait_done) work_d = W_IDLE;
                W_WRITE:  work_d = W_WD;
                W_WD:     if (wait_done) work_d = W_TDAL;
                W_TDAL:   if (wait_done) work_d = W_IDLE;
                W_AR:     work_d = W_TRFC;
                W_TRFC:   if (wait_done) work_d = W_IDLE;
                default:  work_d = W_IDLE;
            endcase
        end

        if (init_d != init_q || work_d != work_q || (init_q == I_DONE && work_q == W_IDLE))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        ref_cnt_d = ref_cnt_q;
        if (init_q == I_DONE) ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;

        // A wrap wins over the clear, so a wrap landing on W_AR entry stays pending.
        ref_pend_d = ref_pend_q;
        if (ref_wrap)
            ref_pend_d = 1'b1;
        else if (work_d == W_AR && work_q != W_AR)
            ref_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= I_NOP;
            work_q     <= W_IDLE;
            cnt_q      <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            is_wr_q    <= 1'b0;
        end else begin
            init_q     <= init_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            is_wr_q    <= is_wr_d;
        end
    end

    assign init_state = init_q;
    assign work_state = work_q;
    assign wr_ack     = (work_q == W_TDAL) && wait_done;
    assign rd_ack     = (work_q == W_RD) && wait_done;
    assign wr_data_en = (work_q == W_WRITE) || (work_q == W_WD);
    assign rd_data_en = (work_q == W_RD);
    assign sdram_busy = (init_q != I_DONE) || (work_q != W_IDLE);

endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// Directed bench for sdram_ctrl_fsm: run-length vector table of per-cycle expected outputs,
// plus a hand-written asynchronous reset during W_RD.
module tb_sdram_ctrl_fsm;

    localparam int P_PWRUP = 40;
`ifdef SDRAM_SIM_FAST_INIT_EN
    localparam int NOP_EXP = 16;
`else
    localparam int NOP_EXP = P_PWRUP;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic       rd_req;
    logic [4:0] init_state;
    logic [3:0] work_state;
    logic       wr_ack;
    logic       rd_ack;
    logic       wr_data_en;
    logic       rd_data_en;
    logic       sdram_busy;

    sdram_ctrl_fsm #(
        .T_PWRUP(P_PWRUP), .T_REFI(780), .T_TRP(1), .T_TRF(4), .T_TMRD(2),
        .T_TRCD(1), .T_CL(2), .T_BL(8), .T_TDAL(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .init_state (init_state),
        .work_state (work_state),
        .wr_ack     (wr_ack),
        .rd_ack     (rd_ack),
        .wr_data_en (wr_data_en),
        .rd_data_en (rd_data_en),
        .sdram_busy (sdram_busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       wr;
        logic       rd;
        logic [4:0] is;
        logic [3:0] ws;
        logic       wde;
        logic       rde;
        logic       wack;
        logic       rack;
        int         n;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int row, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (row %0d, t=%0t): got %0d, expected %0d", name, row, $time, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [4:0] is, input logic [3:0] ws,
                       input logic wde, input logic rde, input logic wack, input logic rack,
                       input int n);
        vec_t v;
        v.wr = wr; v.rd = rd; v.is = is; v.ws = ws;
        v.wde = wde; v.rde = rde; v.wack = wack; v.rack = rack; v.n = n;
        vecs.push_back(v);
    endtask

    // Each row holds its inputs during the cycle and checks the outputs of that cycle.
    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r < hi; r++) begin
            for (int c = 0; c < vecs[r].n; c++) begin
                @(negedge clk);
                wr_req = vecs[r].wr;
                rd_req = vecs[r].rd;
                check("init_state", r, int'(init_state), int'(vecs[r].is));
                check("work_state", r, int'(work_state), int'(vecs[r].ws));
                check("wr_data_en", r, int'(wr_data_en), int'(vecs[r].wde));
                check("rd_data_en", r, int'(rd_data_en), int'(vecs[r].rde));
                check("wr_ack", r, int'(wr_ack), int'(vecs[r].wack));
                check("rd_ack", r, int'(rd_ack), int'(vecs[r].rack));
                check("sdram_busy", r, int'(sdram_busy),
                      (vecs[r].is != 5'd21 || vecs[r].ws != 4'd0) ? 1 : 0);
            end
        end
    endtask

    task automatic add_read(input logic wr, input logic rd);
        add(wr, rd, 21, 1, 0, 0, 0, 0, 1);
        add(wr, rd, 21, 2, 0, 0, 0, 0, 1);
        add(wr, rd, 21, 3, 0, 0, 0, 0, 1);
        add(wr, rd, 21, 4, 0, 0, 0, 0, 2);
        add(wr, rd, 21, 5, 0, 1, 0, 0, 7);
        add(wr, rd, 21, 5, 0, 1, 0, 1, 1);
    endtask

    task automatic add_write(input logic rd_late);
        add(1, 0, 21, 1, 0, 0, 0, 0, 1);
        add(1, rd_late, 21, 2, 0, 0, 0, 0, 1);
        add(1, rd_late, 21, 6, 1, 0, 0, 0, 1);
        add(1, rd_late, 21, 7, 1, 0, 0, 0, 7);
        add(1, rd_late, 21, 8, 0, 0, 0, 0, 1);
        add(1, rd_late, 21, 8, 0, 0, 1, 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_init_state"}, -1, int'(init_state), 0);
        check({tag, "_work_state"}, -1, int'(work_state), 0);
        check({tag, "_wr_ack"}, -1, int'(wr_ack), 0);
        check({tag, "_rd_ack"}, -1, int'(rd_ack), 0);
        check({tag, "_wr_data_en"}, -1, int'(wr_data_en), 0);
        check({tag, "_rd_data_en"}, -1, int'(rd_data_en), 0);
        check({tag, "_sdram_busy"}, -1, int'(sdram_busy), 1);
    endtask

    int init_hi, work_hi, tail_hi;

    initial begin
        rst_n  = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Init chain: NOP, PRE, TRP, 8 x (AR, TRF), MRS, TMRD
        add(0, 0, 0, 0, 0, 0, 0, 0, NOP_EXP);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 2, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            add(0, 0, 5'(2 * k + 1), 0, 0, 0, 0, 0, 1);
            add(0, 0, 5'(2 * k + 2), 0, 0, 0, 0, 0, 4);
        end
        add(0, 0, 19, 0, 0, 0, 0, 0, 1);
        add(0, 0, 20, 0, 0, 0, 0, 0, 2);
        init_hi = vecs.size();

        // t counts cycles from the first I_DONE cycle; refresh wraps land at t=779/1559.
        add(0, 1, 21, 0, 0, 0, 0, 0, 1);       // t0 read request
        add_read(0, 1);                        // t1..t13
        add(1, 0, 21, 0, 0, 0, 0, 0, 1);       // t14 write request
        add_write(0);                          // t15..t26
        add(1, 1, 21, 0, 0, 0, 0, 0, 1);       // t27 both requests: write wins
        add_write(1);                          // t28..t39
        add(0, 1, 21, 0, 0, 0, 0, 0, 1);       // t40 read still pending
        add_read(0, 1);                        // t41..t53
        add(0, 0, 21, 0, 0, 0, 0, 0, 727);     // t54..t780 idle
        add(0, 0, 21, 9, 0, 0, 0, 0, 1);       // t781 auto refresh
        add(0, 0, 21, 10, 0, 0, 0, 0, 4);      // t782..t785
        add(0, 0, 21, 0, 0, 0, 0, 0, 768);     // t786..t1553
        add(1, 0, 21, 0, 0, 0, 0, 0, 1);       // t1554 write request
        add_write(1);                          // t1555..t1566, wrap inside, read arrives
        add(0, 1, 21, 0, 0, 0, 0, 0, 1);       // t1567 refresh beats pending read
        add(0, 1, 21, 9, 0, 0, 0, 0, 1);
        add(0, 1, 21, 10, 0, 0, 0, 0, 4);
        add(0, 1, 21, 0, 0, 0, 0, 0, 1);       // t1573 read served now
        add_read(0, 1);
        add(0, 0, 21, 0, 0, 0, 0, 0, 2);
        work_hi = vecs.size();
        add(0, 0, 21, 0, 0, 0, 0, 0, 3);
        tail_hi = vecs.size();

        repeat (3) @(negedge clk);
        check_reset_values("reset");

        @(posedge clk);
        #1 rst_n = 1'b1;
        run_rows(0, init_hi);
        run_rows(init_hi, work_hi);

        // Asynchronous reset while in W_RD: abort with no ack, then full init again.
        @(negedge clk);
        rd_req = 1'b1;
        check("pre_rd_idle", -1, int'(work_state), 0);
        repeat (6) @(negedge clk);
        check("mid_rd_state", -1, int'(work_state), 5);
        check("mid_rd_data_en", -1, int'(rd_data_en), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        rd_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("held_reset_rd_ack", -1, int'(rd_ack), 0);
            check("held_reset_init", -1, int'(init_state), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_rows(0, init_hi);
        run_rows(work_hi, tail_hi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
